// File: rtl/word_store_pkg.sv
// Shared types and widths for the word store sequencer.
package word_store_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_FIRST  = 2'd1,
    WR_SECOND = 2'd2,
    DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/word_store_sequencer.sv
// Stores a 16-bit word into byte-wide memory as two acknowledged write beats.
// Build option WORD_STORE_HI_FIRST_EN selects big-endian beat order (high byte first).
module word_store_sequencer
  import word_store_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_data,
  input  logic              mem_ack
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   first_byte, second_byte;

  // Beat byte order; handshake and addressing do not depend on it.
`ifdef WORD_STORE_HI_FIRST_EN
  assign first_byte  = word_q[WORD_W-1:BYTE_W];
  assign second_byte = word_q[BYTE_W-1:0];
`else
  assign first_byte  = word_q[BYTE_W-1:0];
  assign second_byte = word_q[WORD_W-1:BYTE_W];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
    end
  end

  // Next state plus Moore output decode; memory bus reads zero outside a beat.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    addr_d   = addr_q;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          word_d  = wdata;
          addr_d  = base_addr;
          state_d = WR_FIRST;
        end
      end
      WR_FIRST: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q;
        mem_data = first_byte;
        if (mem_ack) state_d = WR_SECOND;
      end
      WR_SECOND: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q + ADDR_W'(1);
        mem_data = second_byte;
        if (mem_ack) state_d = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          word_d  = wdata;
          addr_d  = base_addr;
          state_d = WR_FIRST;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_word_store_sequencer.sv
// Self-checking bench for word_store_sequencer: table of stores plus hand-written corner sequences.
module tb_word_store_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] wdata;
  logic [7:0]  base_addr;
  logic        ready, busy, done, mem_we, mem_ack;
  logic [7:0]  mem_addr, mem_data;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } beat_t;

  typedef struct {
    logic [15:0] wdata;
    logic [7:0]  base;
    int          w1;
    int          w2;
    bit          junk;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          lat;
  } vec_t;

  beat_t sb_q[$];

  word_store_sequencer #(.ADDR_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .wdata     (wdata),
    .base_addr (base_addr),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] first_of(input logic [7:0] lo, input logic [7:0] hi);
`ifdef WORD_STORE_HI_FIRST_EN
    return hi;
`else
    return lo;
`endif
  endfunction

  function automatic logic [7:0] second_of(input logic [7:0] lo, input logic [7:0] hi);
`ifdef WORD_STORE_HI_FIRST_EN
    return lo;
`else
    return hi;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every acknowledged beat must match the next expected beat.
  always @(negedge clock) begin
    beat_t b;
    if (!reset && mem_we && mem_ack) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL beat_unexpected: got addr %h data %h expected no beat", mem_addr, mem_data);
      end else begin
        b = sb_q.pop_front();
        chk("beat_addr", 16'(mem_addr), 16'(b.a));
        chk("beat_data", 16'(mem_data), 16'(b.d));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic [7:0] f, s;
    f = first_of(v.lo, v.hi);
    s = second_of(v.lo, v.hi);
    start     = 1'b1;
    wdata     = v.wdata;
    base_addr = v.base;
    mem_ack   = 1'b1;
    sb_q.push_back('{a: v.a1, d: f});
    sb_q.push_back('{a: v.a2, d: s});
    step();
    for (int k = 1; k <= v.lat + 1; k++) begin
      start = v.junk && (k == 1);
      if (v.junk && k == 1) begin
        wdata     = 16'h0000;
        base_addr = 8'h00;
      end
      mem_ack = (k == 1 + v.w1) || (k == 2 + v.w1 + v.w2);
      @(negedge clock);
      chk("done", 16'(done), 16'(k == v.lat));
      if (k <= 1 + v.w1) begin
        chk("b1_we", 16'(mem_we), 16'd1);
        chk("b1_addr", 16'(mem_addr), 16'(v.a1));
        chk("b1_data", 16'(mem_data), 16'(f));
      end else if (k <= 2 + v.w1 + v.w2) begin
        chk("b2_we", 16'(mem_we), 16'd1);
        chk("b2_addr", 16'(mem_addr), 16'(v.a2));
        chk("b2_data", 16'(mem_data), 16'(s));
      end else begin
        chk("post_ready", 16'(ready), 16'd1);
        chk("post_busy", 16'(busy), 16'd0);
        chk("post_we", 16'(mem_we), 16'd0);
        chk("post_bus", {mem_addr, mem_data}, 16'h0000);
      end
      step();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    vec_t tbl[5];
    logic [7:0] exp_a;
    logic       exp_busy;

    tbl[0] = '{16'hA55A, 8'h10, 0, 0, 1'b0, 8'h10, 8'h11, 8'h5A, 8'hA5, 3};
    tbl[1] = '{16'h1234, 8'h40, 3, 1, 1'b0, 8'h40, 8'h41, 8'h34, 8'h12, 7};
    tbl[2] = '{16'hBEEF, 8'hFF, 0, 0, 1'b1, 8'hFF, 8'h00, 8'hEF, 8'hBE, 3};
    tbl[3] = '{16'h00FF, 8'h7F, 1, 2, 1'b0, 8'h7F, 8'h80, 8'hFF, 8'h00, 6};
    tbl[4] = '{16'hFFFF, 8'h00, 0, 2, 1'b1, 8'h00, 8'h01, 8'hFF, 8'hFF, 5};

    reset     = 1'b1;
    start     = 1'b0;
    mem_ack   = 1'b0;
    wdata     = 16'h0;
    base_addr = 8'h0;
    #2;
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_we", 16'(mem_we), 16'd0);
    chk("rst_bus", {mem_addr, mem_data}, 16'h0000);
    step();
    reset = 1'b0;

    // Ack with no beat in flight must not move anything.
    mem_ack = 1'b1;
    @(negedge clock);
    step();
    @(negedge clock);
    chk("idle_ack_ready", 16'(ready), 16'd1);
    chk("idle_ack_we", 16'(mem_we), 16'd0);
    step();
    mem_ack = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Back-to-back: start held through DONE re-enters WR_FIRST without an IDLE cycle.
    start     = 1'b1;
    wdata     = 16'h0102;
    base_addr = 8'h20;
    mem_ack   = 1'b1;
    sb_q.push_back('{a: 8'h20, d: first_of(8'h02, 8'h01)});
    sb_q.push_back('{a: 8'h21, d: second_of(8'h02, 8'h01)});
    sb_q.push_back('{a: 8'h22, d: first_of(8'h04, 8'h03)});
    sb_q.push_back('{a: 8'h23, d: second_of(8'h04, 8'h03)});
    step();
    wdata     = 16'h0304;
    base_addr = 8'h22;
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) start = 1'b0;
      case (k)
        1: exp_a = 8'h20;
        2: exp_a = 8'h21;
        4: exp_a = 8'h22;
        5: exp_a = 8'h23;
        default: exp_a = 8'h00;
      endcase
      exp_busy = (k == 1) || (k == 2) || (k == 4) || (k == 5);
      @(negedge clock);
      chk("b2b_busy", 16'(busy), 16'(exp_busy));
      chk("b2b_done", 16'(done), 16'((k == 3) || (k == 6)));
      chk("b2b_addr", 16'(mem_addr), 16'(exp_a));
      step();
    end
    mem_ack = 1'b0;

    // Reset in WR_SECOND abandons the second beat immediately.
    start     = 1'b1;
    wdata     = 16'h7788;
    base_addr = 8'h30;
    mem_ack   = 1'b1;
    sb_q.push_back('{a: 8'h30, d: first_of(8'h88, 8'h77)});
    step();
    start = 1'b0;
    @(negedge clock);
    step();
    mem_ack = 1'b0;
    chk("mid_we_before", 16'(mem_we), 16'd1);
    chk("mid_addr_before", 16'(mem_addr), 16'h0031);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 16'(mem_we), 16'd0);
    chk("mid_rst_ready", 16'(ready), 16'd1);
    chk("mid_rst_done", 16'(done), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    step();
    reset   = 1'b0;
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("post_rst_we", 16'(mem_we), 16'd0);
      chk("post_rst_ready", 16'(ready), 16'd1);
      step();
    end
    mem_ack = 1'b0;

    chk("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
